// File: rtl/wr_fifo_bus_packer_pkg.sv
// Shared constants for the write-side packer and the read-side interposer.
// Both sides import the half-select encoding so they agree on beat order.
package wr_fifo_bus_packer_pkg;

  localparam int unsigned BUS_WIDTH          = 64;
  localparam int unsigned FIFO_PAYLOAD_WIDTH = 128;
  localparam int unsigned TAG_WIDTH          = 8;
  localparam int unsigned COUNT_WIDTH        = 9;
  localparam int unsigned WR_FIFO_DATA_WIDTH = FIFO_PAYLOAD_WIDTH + TAG_WIDTH;

  // First beat of a pair is the upper half of the 128-bit word.
  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_e;

endpackage

// File: rtl/wr_fifo_bus_packer_if.sv
// Bus-master beat channel, write-FIFO channel and transfer framing for the packer.
interface wr_fifo_bus_packer_if
  import wr_fifo_bus_packer_pkg::*;
#(
  parameter int unsigned WR_FIFO_DATA_WIDTH = wr_fifo_bus_packer_pkg::WR_FIFO_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH        = wr_fifo_bus_packer_pkg::COUNT_WIDTH
);

  logic                          i_start;
  logic [COUNT_WIDTH-1:0]        i_num_words;
  logic [BUS_WIDTH-1:0]          i_bus_master_data;
  logic                          i_bus_master_we;
  logic                          o_bus_master_full;
  logic [WR_FIFO_DATA_WIDTH-1:0] o_wr_fifo_data;
  logic                          o_wr_fifo_we;
  logic                          i_wr_fifo_full;
  logic                          o_active;
  logic                          o_done;

  // The packer is the slave of the bus master and drives the FIFO.
  modport slave (
    input  i_start, i_num_words, i_bus_master_data, i_bus_master_we, i_wr_fifo_full,
    output o_bus_master_full, o_wr_fifo_data, o_wr_fifo_we, o_active, o_done
  );

  modport master (
    output i_start, i_num_words, i_bus_master_data, i_bus_master_we, i_wr_fifo_full,
    input  o_bus_master_full, o_wr_fifo_data, o_wr_fifo_we, o_active, o_done
  );

endinterface

// File: rtl/wr_fifo_bus_packer.sv
// Packs pairs of 64-bit bus beats (upper first) into tagged 128-bit words and
// writes them into the flash controller write FIFO through a one-entry holding register.
module wr_fifo_bus_packer
  import wr_fifo_bus_packer_pkg::*;
#(
  parameter int unsigned WR_FIFO_DATA_WIDTH = wr_fifo_bus_packer_pkg::WR_FIFO_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH          = wr_fifo_bus_packer_pkg::TAG_WIDTH,
  parameter int unsigned COUNT_WIDTH        = wr_fifo_bus_packer_pkg::COUNT_WIDTH
) (
  input logic                  i_clk,
  input logic                  i_rst,
  wr_fifo_bus_packer_if.slave  bus
);

  logic [BUS_WIDTH-1:0]          hi_q, hi_d;
  half_e                         half_q, half_d;
  logic [WR_FIFO_DATA_WIDTH-1:0] out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic [COUNT_WIDTH-1:0]        pack_cnt_q, pack_cnt_d;
  logic [COUNT_WIDTH-1:0]        remaining_q, remaining_d;
  logic                          active_q, active_d;
  logic                          zero_done_q, zero_done_d;

  logic active_pack;
  logic full;
  logic accept;
  logic fifo_we;
  logic last_write;
  logic done;

  always_comb begin
    active_pack = active_q && (pack_cnt_q < remaining_q);
    // Only the lower beat needs out_q free; an upper beat lands in hi_q.
    full        = i_rst || !active_pack ||
                  ((half_q == HALF_LOWER) && out_valid_q && bus.i_wr_fifo_full);
    accept      = bus.i_bus_master_we && !full;
    fifo_we     = !i_rst && out_valid_q && !bus.i_wr_fifo_full;
    // A new word cannot replace a pending one before it is written, so
    // pack_cnt == remaining while writing means this is the final word.
    last_write  = fifo_we && active_q && (pack_cnt_q == remaining_q);
    done        = last_write || (zero_done_q && !i_rst);
  end

  always_comb begin
    hi_d        = hi_q;
    half_d      = half_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pack_cnt_d  = pack_cnt_q;
    remaining_d = remaining_q;
    active_d    = active_q;
    zero_done_d = 1'b0;

    if (fifo_we) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (half_q == HALF_UPPER) begin
        hi_d   = bus.i_bus_master_data;
        half_d = HALF_LOWER;
      end else begin
        out_d       = {pack_cnt_q[TAG_WIDTH-1:0], hi_q, bus.i_bus_master_data};
        out_valid_d = 1'b1;
        half_d      = HALF_UPPER;
        pack_cnt_d  = pack_cnt_q + COUNT_WIDTH'(1);
      end
    end

    if (last_write) begin
      active_d = 1'b0;
    end

    if (bus.i_start && !active_q && !done) begin
      if (bus.i_num_words != '0) begin
        active_d    = 1'b1;
        remaining_d = bus.i_num_words;
        pack_cnt_d  = '0;
        half_d      = HALF_UPPER;
      end else begin
        zero_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_q        <= '0;
      half_q      <= HALF_UPPER;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pack_cnt_q  <= '0;
      remaining_q <= '0;
      active_q    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      half_q      <= half_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pack_cnt_q  <= pack_cnt_d;
      remaining_q <= remaining_d;
      active_q    <= active_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign bus.o_bus_master_full = full;
  assign bus.o_wr_fifo_we      = fifo_we;
  assign bus.o_wr_fifo_data    = out_q;
  assign bus.o_active          = active_q;
  assign bus.o_done            = done;

endmodule

// File: tb/tb_wr_fifo_bus_packer.sv
// Directed bench for wr_fifo_bus_packer: packing, tagging, backpressure, framing and reset.
module tb_wr_fifo_bus_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wr_fifo_bus_packer_if #(.WR_FIFO_DATA_WIDTH(136), .COUNT_WIDTH(9)) bus ();

  wr_fifo_bus_packer #(
    .WR_FIFO_DATA_WIDTH(136),
    .TAG_WIDTH         (8),
    .COUNT_WIDTH       (9)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [135:0] wr_q[$];
  int unsigned  done_cnt  = 0;
  int unsigned  done_widx = 0;
  int unsigned  abuse_cnt = 0;

  // Inputs change just after posedge, so the negedge sees the values the next edge acts on.
  always @(negedge clk) begin
    if (bus.o_wr_fifo_we) wr_q.push_back(bus.o_wr_fifo_data);
    if (bus.o_done) begin
      done_cnt  <= done_cnt + 1;
      done_widx <= wr_q.size();
    end
    if (bus.i_bus_master_we && bus.o_bus_master_full && !rst) abuse_cnt <= abuse_cnt + 1;
  end

  task automatic drive(input logic st, input logic [8:0] num, input logic we,
                       input logic [63:0] data, input logic ffull);
    @(posedge clk);
    #1;
    bus.i_start           = st;
    bus.i_num_words       = num;
    bus.i_bus_master_we   = we;
    bus.i_bus_master_data = data;
    bus.i_wr_fifo_full    = ffull;
    #1;
  endtask

  function automatic logic [63:0] beat(input int unsigned j);
    return {32'hB0B0_0000, j};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 9'd0, 0, 64'd0, 0);
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bus.o_wr_fifo_we); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.o_done); end
    checks++; if (bus.o_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", bus.o_active); end
    checks++; if (bus.o_bus_master_full !== 1'b1) begin failures++; $display("FAIL reset_full got=%b want=1", bus.o_bus_master_full); end
    checks++; if (bus.o_wr_fifo_data !== 136'd0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.o_wr_fifo_data); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_pack_tag();
    logic [63:0] a1 = 64'hA1A1_A1A1_0000_0001, a0 = 64'hA0A0_A0A0_0000_0000;
    logic [63:0] b1 = 64'hB1B1_B1B1_0000_0011, b0 = 64'hB0B0_B0B0_0000_0010;
    int unsigned base = wr_q.size();
    int unsigned d0   = done_cnt;
    drive(1, 9'd2, 0, 64'd0, 0);
    drive(0, 9'd0, 1, a1, 0);
    checks++; if (bus.o_active !== 1'b1) begin failures++; $display("FAIL pack_active got=%b want=1", bus.o_active); end
    checks++; if (bus.o_bus_master_full !== 1'b0) begin failures++; $display("FAIL pack_full_upper got=%b want=0", bus.o_bus_master_full); end
    drive(0, 9'd0, 1, a0, 0);
    drive(0, 9'd0, 1, b1, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h00, a1, a0}) begin
      failures++; $display("FAIL pack_word0 we=%b data=%h want=1 %h", bus.o_wr_fifo_we, bus.o_wr_fifo_data, {8'h00, a1, a0}); end
    drive(0, 9'd0, 1, b0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b0) begin failures++; $display("FAIL pack_gap_we got=%b want=0", bus.o_wr_fifo_we); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h01, b1, b0}) begin
      failures++; $display("FAIL pack_word1 we=%b data=%h want=1 %h", bus.o_wr_fifo_we, bus.o_wr_fifo_data, {8'h01, b1, b0}); end
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL pack_done got=%b want=1", bus.o_done); end
    checks++; if (bus.o_bus_master_full !== 1'b1) begin failures++; $display("FAIL pack_full_after got=%b want=1", bus.o_bus_master_full); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_active !== 1'b0 || bus.o_done !== 1'b0) begin
      failures++; $display("FAIL pack_end active=%b done=%b want=0 0", bus.o_active, bus.o_done); end
    checks++; if (wr_q.size() - base != 2 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL pack_counts writes=%0d dones=%0d want=2 1", wr_q.size() - base, done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [63:0] c1 = 64'hC1, c0 = 64'hC0, e1 = 64'hE1, e0 = 64'hE0;
    logic [63:0] f1 = 64'hD1, f0 = 64'hD0;
    int unsigned base = wr_q.size();
    drive(1, 9'd3, 0, 64'd0, 0);
    drive(0, 9'd0, 1, c1, 0);
    drive(0, 9'd0, 1, c0, 0);
    drive(0, 9'd0, 1, f1, 1);
    checks++; if (bus.o_bus_master_full !== 1'b0 || bus.o_wr_fifo_we !== 1'b0) begin
      failures++; $display("FAIL bp_upper full=%b we=%b want=0 0", bus.o_bus_master_full, bus.o_wr_fifo_we); end
    drive(0, 9'd0, 1, f0, 1);
    checks++; if (bus.o_bus_master_full !== 1'b1) begin failures++; $display("FAIL bp_lower_stall got=%b want=1", bus.o_bus_master_full); end
    drive(0, 9'd0, 1, f0, 1);
    checks++; if (bus.o_bus_master_full !== 1'b1 || bus.o_wr_fifo_we !== 1'b0) begin
      failures++; $display("FAIL bp_hold full=%b we=%b want=1 0", bus.o_bus_master_full, bus.o_wr_fifo_we); end
    drive(0, 9'd0, 1, f0, 0);
    checks++; if (bus.o_bus_master_full !== 1'b0 || bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h00, c1, c0}) begin
      failures++; $display("FAIL bp_release full=%b we=%b data=%h want=0 1 %h", bus.o_bus_master_full, bus.o_wr_fifo_we, bus.o_wr_fifo_data, {8'h00, c1, c0}); end
    drive(0, 9'd0, 1, e1, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h01, f1, f0}) begin
      failures++; $display("FAIL bp_word1 we=%b data=%h want=1 %h", bus.o_wr_fifo_we, bus.o_wr_fifo_data, {8'h01, f1, f0}); end
    drive(0, 9'd0, 1, e0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b0) begin failures++; $display("FAIL bp_gap_we got=%b want=0", bus.o_wr_fifo_we); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h02, e1, e0} || bus.o_done !== 1'b1) begin
      failures++; $display("FAIL bp_word2 we=%b done=%b data=%h want=1 1 %h", bus.o_wr_fifo_we, bus.o_done, bus.o_wr_fifo_data, {8'h02, e1, e0}); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (wr_q.size() - base != 3 || bus.o_active !== 1'b0) begin
      failures++; $display("FAIL bp_counts writes=%0d active=%b want=3 0", wr_q.size() - base, bus.o_active); end
  endtask

  task automatic test_zero_length();
    int unsigned base = wr_q.size();
    int unsigned d0   = done_cnt;
    drive(1, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_done !== 1'b0 || bus.o_active !== 1'b0) begin
      failures++; $display("FAIL zero_start done=%b active=%b want=0 0", bus.o_done, bus.o_active); end
    // Start in the same cycle as the done pulse must be ignored.
    drive(1, 9'd1, 0, 64'd0, 0);
    checks++; if (bus.o_done !== 1'b1 || bus.o_active !== 1'b0 || bus.o_wr_fifo_we !== 1'b0) begin
      failures++; $display("FAIL zero_done done=%b active=%b we=%b want=1 0 0", bus.o_done, bus.o_active, bus.o_wr_fifo_we); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_done !== 1'b0 || bus.o_active !== 1'b0) begin
      failures++; $display("FAIL zero_after done=%b active=%b want=0 0", bus.o_done, bus.o_active); end
    checks++; if (wr_q.size() != base || done_cnt - d0 != 1) begin
      failures++; $display("FAIL zero_counts writes=%0d dones=%0d want=0 1", wr_q.size() - base, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] g1 = 64'h6161, g0 = 64'h6060, h1 = 64'h7171, k1 = 64'h8181, k0 = 64'h8080;
    int unsigned base = wr_q.size();
    drive(1, 9'd2, 0, 64'd0, 0);
    drive(0, 9'd0, 1, g1, 0);
    drive(0, 9'd0, 1, g0, 0);
    drive(0, 9'd0, 1, h1, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.i_wr_fifo_full = 1'b0; bus.i_bus_master_we = 1'b0;
    #1;
    checks++; if (bus.o_wr_fifo_we !== 1'b0 || bus.o_done !== 1'b0 || bus.o_bus_master_full !== 1'b1) begin
      failures++; $display("FAIL rstmid_cycle we=%b done=%b full=%b want=0 0 1", bus.o_wr_fifo_we, bus.o_done, bus.o_bus_master_full); end
    @(posedge clk); #1; rst = 1'b0; #1;
    checks++; if (bus.o_active !== 1'b0 || bus.o_wr_fifo_data !== 136'd0 || bus.o_wr_fifo_we !== 1'b0) begin
      failures++; $display("FAIL rstmid_state active=%b we=%b data=%h want=0 0 0", bus.o_active, bus.o_wr_fifo_we, bus.o_wr_fifo_data); end
    drive(1, 9'd1, 0, 64'd0, 0);
    drive(0, 9'd0, 1, k1, 0);
    drive(0, 9'd0, 1, k0, 0);
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_wr_fifo_we !== 1'b1 || bus.o_wr_fifo_data !== {8'h00, k1, k0} || bus.o_done !== 1'b1) begin
      failures++; $display("FAIL rstmid_new we=%b done=%b data=%h want=1 1 %h", bus.o_wr_fifo_we, bus.o_done, bus.o_wr_fifo_data, {8'h00, k1, k0}); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (wr_q.size() - base != 1) begin failures++; $display("FAIL rstmid_writes got=%0d want=1", wr_q.size() - base); end
  endtask

  task automatic test_tag_wrap();
    int unsigned base   = wr_q.size();
    int unsigned stalls = 0;
    drive(1, 9'd257, 0, 64'd0, 0);
    for (int unsigned j = 0; j < 514; j++) begin
      drive(0, 9'd0, 1, beat(j), 0);
      if (bus.o_bus_master_full) stalls++;
    end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b want=1", bus.o_done); end
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (stalls != 0) begin failures++; $display("FAIL wrap_stalls got=%0d want=0", stalls); end
    checks++; if (wr_q.size() - base != 257) begin failures++; $display("FAIL wrap_writes got=%0d want=257", wr_q.size() - base); end
    checks++; if (done_widx != base + 257) begin failures++; $display("FAIL wrap_done_index got=%0d want=%0d", done_widx, base + 257); end
    if (wr_q.size() >= base + 257) begin
      checks++; if (wr_q[base+255] !== {8'hFF, beat(510), beat(511)}) begin
        failures++; $display("FAIL wrap_word255 got=%h want=%h", wr_q[base+255], {8'hFF, beat(510), beat(511)}); end
      checks++; if (wr_q[base+256] !== {8'h00, beat(512), beat(513)}) begin
        failures++; $display("FAIL wrap_word256 got=%h want=%h", wr_q[base+256], {8'h00, beat(512), beat(513)}); end
    end
  endtask

  task automatic test_protocol_abuse();
    int unsigned base = wr_q.size();
    int unsigned d0   = done_cnt;
    int unsigned a0   = abuse_cnt;
    drive(1, 9'd2, 0, 64'd0, 0);
    drive(0, 9'd0, 1, 64'h51, 0);
    drive(1, 9'd5, 1, 64'h50, 0);
    drive(0, 9'd0, 1, 64'h53, 0);
    drive(0, 9'd0, 1, 64'h52, 0);
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (bus.o_done !== 1'b1 || bus.o_wr_fifo_data !== {8'h01, 64'h53, 64'h52}) begin
      failures++; $display("FAIL abuse_done done=%b data=%h want=1 %h", bus.o_done, bus.o_wr_fifo_data, {8'h01, 64'h53, 64'h52}); end
    drive(0, 9'd0, 1, 64'hDEAD, 0);
    drive(0, 9'd0, 1, 64'hBEEF, 0);
    drive(0, 9'd0, 0, 64'd0, 0);
    checks++; if (abuse_cnt - a0 != 2) begin failures++; $display("FAIL abuse_flagged got=%0d want=2", abuse_cnt - a0); end
    checks++; if (wr_q.size() - base != 2 || done_cnt - d0 != 1 || bus.o_active !== 1'b0) begin
      failures++; $display("FAIL abuse_counts writes=%0d dones=%0d active=%b want=2 1 0", wr_q.size() - base, done_cnt - d0, bus.o_active); end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_num_words = '0; bus.i_bus_master_we = 1'b0;
    bus.i_bus_master_data = '0; bus.i_wr_fifo_full = 1'b0;
    test_reset();
    test_pack_tag();
    test_backpressure();
    test_zero_length();
    test_reset_mid();
    test_tag_wrap();
    test_protocol_abuse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
